cpu_0_mul_seq: RTL and testbench

Multi-cycle sequencer that computes full 64-bit products (Nios II MUL, MULXUU, MULXSS, MULXSU) by driving the 32-bit low-product multiplier cell with zero-extended 16-bit operand halves and accumulating the four partial products. It sits upstream of the multiplier cell, which consumes its operand outputs, and downstream of it for the cell's result. Results go back to the CPU A-stage through a start/busy/done handshake.

---
 rtl/cpu_0_mul_seq.sv | 168 ++++++++++++++++
 tb/tb_cpu_0_mul_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_0_mul_seq.sv
// cpu_0_mul_seq: builds 64-bit Nios II products from four 16x16 passes through a 32-bit low-product cell.
// Optional macro MUL_SIGNED_EN adds the FIX state for signed high words (MULXSS/MULXSU).
module cpu_0_mul_seq #(
   parameter int CELL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   input  logic [31:0] cell_result,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_hi,
   output logic [31:0] result_lo,
   output logic [2:0]  dbg_state,
   output logic [1:0]  dbg_op
);

   // Handshake: start is taken only while busy=0; busy covers accept+1 through the done
   // cycle; done pulses for one cycle and result_hi/lo hold until the next accepted start.
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIX, S_DONE} state_t;

   state_t      r_state;
   logic [1:0]  r_idx;
   logic [1:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [63:0] r_acc;
   logic [31:0] r_cell_src1;
   logic [31:0] r_cell_src2;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_res_hi;
   logic [31:0] r_res_lo;
   logic        r_tag_v   [CELL_LATENCY];
   logic [1:0]  r_tag_idx [CELL_LATENCY];

   logic [63:0] w_contrib;
   logic [63:0] w_acc_next;
   logic        w_last;
   logic [1:0]  w_idx_nxt;
   logic [15:0] w_a_half;
   logic [15:0] w_b_half;

   // idx[0] selects the high half of a, idx[1] the high half of b
   assign w_idx_nxt = r_idx + 2'd1;
   assign w_a_half  = w_idx_nxt[0] ? r_a[31:16] : r_a[15:0];
   assign w_b_half  = w_idx_nxt[1] ? r_b[31:16] : r_b[15:0];
   assign w_last    = r_tag_v[CELL_LATENCY-1] && (r_tag_idx[CELL_LATENCY-1] == 2'd3);

   always_comb begin
      w_contrib = 64'd0;
      case (r_tag_idx[CELL_LATENCY-1])
         2'd0:       w_contrib = {32'd0, cell_result};
         2'd1, 2'd2: w_contrib = {16'd0, cell_result, 16'd0};
         default:    w_contrib = {cell_result, 32'd0};
      endcase
      w_acc_next = r_acc + (r_tag_v[CELL_LATENCY-1] ? w_contrib : 64'd0);
   end

`ifdef MUL_SIGNED_EN
   logic [31:0] w_corr_a;
   logic [31:0] w_corr_b;
   assign w_corr_a = (r_op[1] && r_a[31]) ? r_b : 32'd0;
   assign w_corr_b = ((r_op == 2'b10) && r_b[31]) ? r_a : 32'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CELL_LATENCY; i++) begin
            r_tag_v[i]   <= 1'b0;
            r_tag_idx[i] <= 2'd0;
         end
      end else begin
         r_tag_v[0]   <= (r_state == S_ISSUE);
         r_tag_idx[0] <= r_idx;
         for (int i = 1; i < CELL_LATENCY; i++) begin
            r_tag_v[i]   <= r_tag_v[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= 2'd0;
         r_op        <= 2'd0;
         r_a         <= 32'd0;
         r_b         <= 32'd0;
         r_acc       <= 64'd0;
         r_cell_src1 <= 32'd0;
         r_cell_src2 <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_hi    <= 32'd0;
         r_res_lo    <= 32'd0;
      end else begin
         r_acc <= w_acc_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op        <= op;
                  r_a         <= src1;
                  r_b         <= src2;
                  r_acc       <= 64'd0;
                  r_idx       <= 2'd0;
                  r_cell_src1 <= {16'd0, src1[15:0]};
                  r_cell_src2 <= {16'd0, src2[15:0]};
                  r_busy      <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_idx == 2'd3) begin
                  r_cell_src1 <= 32'd0;
                  r_cell_src2 <= 32'd0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_idx       <= w_idx_nxt;
                  r_cell_src1 <= {16'd0, w_a_half};
                  r_cell_src2 <= {16'd0, w_b_half};
               end
            end
            S_DRAIN: begin
               if (w_last) begin
`ifdef MUL_SIGNED_EN
                  r_state  <= S_FIX;
`else
                  r_done   <= 1'b1;
                  r_res_hi <= w_acc_next[63:32];
                  r_res_lo <= w_acc_next[31:0];
                  r_state  <= S_DONE;
`endif
               end
            end
`ifdef MUL_SIGNED_EN
            S_FIX: begin
               r_done   <= 1'b1;
               r_res_hi <= r_acc[63:32] - w_corr_a - w_corr_b;
               r_res_lo <= r_acc[31:0];
               r_state  <= S_DONE;
            end
`endif
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cell_src1 = r_cell_src1;
   assign cell_src2 = r_cell_src2;
   assign busy      = r_busy;
   assign done      = r_done;
   assign result_hi = r_res_hi;
   assign result_lo = r_res_lo;
   assign dbg_state = r_state;
   assign dbg_op    = r_op;

endmodule

// File: tb/tb_cpu_0_mul_seq.sv
// tb_cpu_0_mul_seq: drives two sequencers (cell latency 1 and 2), each with its own multiplier
// cell model, and scores products, latency, busy/done and cell operands against a reference.
module tb_cpu_0_mul_seq;

`ifdef MUL_SIGNED_EN
   localparam int FIX_CYC = 1;
`else
   localparam int FIX_CYC = 0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start_v  [2];
   logic [1:0]  op_v     [2];
   logic [31:0] src1_v   [2];
   logic [31:0] src2_v   [2];
   logic [31:0] csrc1_v  [2];
   logic [31:0] csrc2_v  [2];
   logic [31:0] cres_v   [2];
   logic        busy_v   [2];
   logic        done_v   [2];
   logic [31:0] rhi_v    [2];
   logic [31:0] rlo_v    [2];
   logic [2:0]  dbgs_v   [2];
   logic [1:0]  dbgo_v   [2];
   logic [31:0] pipe1;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   cpu_0_mul_seq #(.CELL_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .op(op_v[0]),
      .src1(src1_v[0]), .src2(src2_v[0]),
      .cell_src1(csrc1_v[0]), .cell_src2(csrc2_v[0]), .cell_result(cres_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .result_hi(rhi_v[0]), .result_lo(rlo_v[0]),
      .dbg_state(dbgs_v[0]), .dbg_op(dbgo_v[0])
   );

   cpu_0_mul_seq #(.CELL_LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .start(start_v[1]), .op(op_v[1]),
      .src1(src1_v[1]), .src2(src2_v[1]),
      .cell_src1(csrc1_v[1]), .cell_src2(csrc2_v[1]), .cell_result(cres_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .result_hi(rhi_v[1]), .result_lo(rlo_v[1]),
      .dbg_state(dbgs_v[1]), .dbg_op(dbgo_v[1])
   );

   // multiplier cell models: low 32 bits of the product, 1 and 2 register stages
   always @(posedge clk) begin
      cres_v[0] <= 32'(csrc1_v[0] * csrc2_v[0]);
      pipe1     <= 32'(csrc1_v[1] * csrc2_v[1]);
      cres_v[1] <= pipe1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // full product from sign-extended operands, mod 2^64
   function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb;
      logic sa, sb;
      sa = (FIX_CYC == 1) && op[1];
      sb = (FIX_CYC == 1) && (op == 2'b10);
      ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   function automatic logic [63:0] issue_ops(input int idx, input logic [31:0] a,
                                             input logic [31:0] b);
      case (idx)
         0:       return {16'd0, a[15:0],  16'd0, b[15:0]};
         1:       return {16'd0, a[31:16], 16'd0, b[15:0]};
         2:       return {16'd0, a[15:0],  16'd0, b[31:16]};
         default: return {16'd0, a[31:16], 16'd0, b[31:16]};
      endcase
   endfunction

   // called at a negedge; start is sampled on the following posedge (cycle T)
   task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      int lat, first, busy_cnt, done_cnt;
      logic [63:0] exp;
      lat = 6 + d + FIX_CYC;
      first = 0; busy_cnt = 0; done_cnt = 0;
      start_v[d] = 1'b1; op_v[d] = op; src1_v[d] = a; src2_v[d] = b;
      exp_q.push_back(ref_mul(op, a, b));
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start_v[d] = poke && (n == 3 || n == lat);
         op_v[d]    = 2'($urandom_range(0, 3));
         src1_v[d]  = $urandom;
         src2_v[d]  = $urandom;
         if (n <= 4) check("cell_ops", {csrc1_v[d], csrc2_v[d]}, issue_ops(n - 1, a, b));
         if (first == 0) begin
            if (busy_v[d]) busy_cnt++;
            if (done_v[d]) begin
               first = n;
               done_cnt++;
               check("cell_idle", {csrc1_v[d], csrc2_v[d]}, 64'd0);
            end
         end else begin
            if (done_v[d]) done_cnt++;
            check("busy_after", {63'd0, busy_v[d]}, 64'd0);
            break;
         end
      end
      start_v[d] = 1'b0;
      exp = exp_q.pop_front();
      check("latency", 64'(first), 64'(lat));
      check("busy_span", 64'(busy_cnt), 64'(lat));
      check("done_pulse", 64'(done_cnt), 64'd1);
      check("product", {rhi_v[d], rlo_v[d]}, exp);
   endtask

   task automatic reset_mid(input int d);
      start_v[d] = 1'b1; op_v[d] = 2'b01; src1_v[d] = 32'hFFFF_FFFF; src2_v[d] = 32'hFFFF_FFFF;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         start_v[d] = 1'b0;
         if (n == 3) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy", {63'd0, busy_v[d]}, 64'd0);
      check("rst_done", {63'd0, done_v[d]}, 64'd0);
      check("rst_result", {rhi_v[d], rlo_v[d]}, 64'd0);
      check("rst_cell", {csrc1_v[d], csrc2_v[d]}, 64'd0);
      run_op(d, 2'b01, 32'd3, 32'd5, 1'b0);
      check("post_rst_15", {rhi_v[d], rlo_v[d]}, 64'd15);
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_v[d] = 1'b0; op_v[d] = 2'd0; src1_v[d] = 32'd0; src2_v[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("init_busy", {63'd0, busy_v[d]}, 64'd0);
         check("init_done", {63'd0, done_v[d]}, 64'd0);
         check("init_result", {rhi_v[d], rlo_v[d]}, 64'd0);
         check("init_cell", {csrc1_v[d], csrc2_v[d]}, 64'd0);
      end
      for (int d = 0; d < 2; d++) begin
         run_op(d, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
         check("uu_max", {rhi_v[d], rlo_v[d]}, 64'hFFFF_FFFE_0000_0001);
         run_op(d, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
         run_op(d, 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0);
         run_op(d, 2'b11, 32'h8000_0000, 32'h0000_0002, 1'b0);
         run_op(d, 2'b00, 32'h0001_2345, 32'h0001_0000, 1'b0);
         check("mul_lo", {32'd0, rlo_v[d]}, 64'h2345_0000);
         run_op(d, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
         run_op(d, 2'b10, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0);
         reset_mid(d);
         for (int k = 0; k < 12; k++)
            run_op(d, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
